// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file geometry for the writeback arbiter.
// Width defaults and address/data types used by the top and the bench.
package rf_wb_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin one-hot grant: first valid request at or after ptr, modulo NREQ.
// Combinational, zero latency; enable=0 forces an all-zero grant.
// No storage; the caller owns the pointer and decides when it advances.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters; RF_WB_BYPASS_EN adds read forwarding.
// Latency: one cycle from handshake to registered regW/wrA/wrD.
// Backpressure: combinational req_ready, one grant per cycle, none while freeze is high.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               freeze,
`ifdef RF_WB_BYPASS_EN
    input  logic [AW-1:0]      r1A,
    input  logic [AW-1:0]      r2A,
    input  logic [DW-1:0]      rf_r1d,
    input  logic [DW-1:0]      rf_r2d,
    output logic [DW-1:0]      r1d,
    output logic [DW-1:0]      r2d,
`endif
    output logic               regW,
    output logic [AW-1:0]      wrA,
    output logic [DW-1:0]      wrD,
    output logic               conflict,
    output logic [CNTW-1:0]    wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_ADDR);

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic          xfer;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_nonzero;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (!freeze),
        .grant  (req_ready)
    );

    // Grant is one-hot, so at most one iteration fires.
    always_comb begin
        xfer     = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        next_ptr = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                xfer     = 1'b1;
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                next_ptr = PW'((i + 1) % NREQ);
            end
        end
        sel_nonzero = (sel_addr != ZERO_ADDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regW     <= 1'b0;
            wrA      <= '0;
            wrD      <= '0;
            conflict <= 1'b0;
            wr_count <= '0;
            ptr      <= '0;
        end else begin
            conflict <= ($countones(req_valid) >= 2);
            regW     <= xfer && sel_nonzero;
            if (xfer) begin
                wrA <= sel_addr;
                wrD <= sel_data;
                ptr <= next_ptr;
            end
            if (xfer && sel_nonzero && (wr_count != '1))
                wr_count <= wr_count + CNTW'(1);
        end
    end

`ifdef RF_WB_BYPASS_EN
    // $zero is never forwarded; it must always read as the register-file value.
    assign r1d = (regW && (wrA == r1A) && (r1A != ZERO_ADDR)) ? wrD : rf_r1d;
    assign r2d = (regW && (wrA == r2A) && (r2A != ZERO_ADDR)) ? wrD : rf_r2d;
`endif

endmodule
